// File: rtl/regbank_wb_scheduler_pkg.sv
// Shared definitions for the register-bank writeback scheduler.
package regbank_wb_scheduler_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned SP_INDEX  = 16;
  localparam int unsigned ZERO_REG  = 0;

  typedef enum logic [1:0] {
    SP_OP_NONE = 2'b00,
    SP_OP_PUSH = 2'b01,
    SP_OP_POP  = 2'b10,
    SP_OP_RSVD = 2'b11
  } sp_op_e;

  // True when idx names a writable GPR: not r0, not SP, and within the tracked range.
  function automatic logic is_gpr(input logic [REG_IDX_W-1:0] idx, input int unsigned nreg);
    return (32'(idx) != ZERO_REG) && (32'(idx) != SP_INDEX) && (32'(idx) < nreg);
  endfunction

endpackage

// File: rtl/regbank_wb_scheduler_rr_arbiter2.sv
// Two-requester round-robin arbiter; the priority pointer flips only after a contended grant.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt_c
);

  logic ptr_q;  // 0: requester 0 has priority
  logic ptr_d;

  always_comb begin
    gnt_c = 2'b00;
    ptr_d = ptr_q;
    if (!rst) begin
      case (req)
        2'b01:   gnt_c = 2'b01;
        2'b10:   gnt_c = 2'b10;
        2'b11: begin
          gnt_c = ptr_q ? 2'b10 : 2'b01;
          ptr_d = ~ptr_q;
        end
        default: gnt_c = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regbank_wb_scheduler.sv
// Register-bank write sequencer: GPR writeback arbitration, pending-write scoreboard
// and SP push/pop update with a sticky wrap fault.
module regbank_wb_scheduler
  import regbank_wb_scheduler_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NREG    = 16,
  parameter int unsigned SP_STEP = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_valid,
  input  logic [REG_IDX_W-1:0] a_reg,
  input  logic [DATA_W-1:0]    a_data,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [REG_IDX_W-1:0] b_reg,
  input  logic [DATA_W-1:0]    b_data,
  output logic                 b_ready,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_reg,
  output logic [NREG-1:0]      busy,
  input  logic [1:0]           sp_op,
  input  logic [DATA_W-1:0]    sp_in,
  output logic                 reg_write,
  output logic [REG_IDX_W-1:0] write_reg,
  output logic [DATA_W-1:0]    write_data,
  output logic                 sp_write,
  output logic [DATA_W-1:0]    sp_wdata,
  output logic                 sp_fault
);

  localparam logic [DATA_W-1:0] STEP    = DATA_W'(SP_STEP);
  localparam logic [DATA_W-1:0] POP_MAX = {DATA_W{1'b1}} - STEP;

  logic [1:0]           gnt;
  logic [REG_IDX_W-1:0] sel_reg;
  logic [DATA_W-1:0]    sel_data;
  logic                 wr_en;

  logic                 reg_write_q,  reg_write_d;
  logic [REG_IDX_W-1:0] write_reg_q,  write_reg_d;
  logic [DATA_W-1:0]    write_data_q, write_data_d;
  logic [NREG-1:0]      busy_q,       busy_d;
  logic                 sp_write_q,   sp_write_d;
  logic [DATA_W-1:0]    sp_wdata_q,   sp_wdata_d;
  logic                 sp_fault_q,   sp_fault_d;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   ({b_valid, a_valid}),
    .gnt_c (gnt)
  );

  assign a_ready = gnt[0];
  assign b_ready = gnt[1];

  // GPR port and scoreboard; r0 and out-of-range grants are consumed without effect.
  always_comb begin
    sel_reg      = gnt[1] ? b_reg  : a_reg;
    sel_data     = gnt[1] ? b_data : a_data;
    wr_en        = (|gnt) && is_gpr(sel_reg, NREG);
    reg_write_d  = wr_en;
    write_reg_d  = wr_en ? sel_reg  : write_reg_q;
    write_data_d = wr_en ? sel_data : write_data_q;
    busy_d       = busy_q;
    for (int i = 1; i < int'(NREG); i++) begin
      if (wr_en && (32'(sel_reg) == 32'(i))) busy_d[i] = 1'b0;
      // A newer producer issued this cycle outranks the retiring write.
      if (issue_valid && is_gpr(issue_reg, NREG) && (32'(issue_reg) == 32'(i))) busy_d[i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // SP update; a wrapping push/pop is suppressed and latches the fault.
  always_comb begin
    sp_write_d = 1'b0;
    sp_wdata_d = sp_wdata_q;
    sp_fault_d = sp_fault_q;
    case (sp_op_e'(sp_op))
      SP_OP_PUSH: begin
        if (sp_in < STEP) begin
          sp_fault_d = 1'b1;
        end else begin
          sp_write_d = 1'b1;
          sp_wdata_d = sp_in - STEP;
        end
      end
      SP_OP_POP: begin
        if (sp_in > POP_MAX) begin
          sp_fault_d = 1'b1;
        end else begin
          sp_write_d = 1'b1;
          sp_wdata_d = sp_in + STEP;
        end
      end
      default: sp_write_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      busy_q       <= '0;
      sp_write_q   <= 1'b0;
      sp_wdata_q   <= '0;
      sp_fault_q   <= 1'b0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      busy_q       <= busy_d;
      sp_write_q   <= sp_write_d;
      sp_wdata_q   <= sp_wdata_d;
      sp_fault_q   <= sp_fault_d;
    end
  end

  assign reg_write  = reg_write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign busy       = busy_q;
  assign sp_write   = sp_write_q;
  assign sp_wdata   = sp_wdata_q;
  assign sp_fault   = sp_fault_q;

endmodule

// File: tb/tb_regbank_wb_scheduler.sv
// Bench for regbank_wb_scheduler: directed vector table, a held-loser contention
// sequence, and randomized traffic against a behavioural model.
module tb_regbank_wb_scheduler;

  logic        clk = 1'b1;
  logic        rst;
  logic        a_valid, b_valid, issue_valid;
  logic [4:0]  a_reg, b_reg, issue_reg, write_reg;
  logic [31:0] a_data, b_data, sp_in, write_data, sp_wdata;
  logic        a_ready, b_ready, reg_write, sp_write, sp_fault;
  logic [15:0] busy;
  logic [1:0]  sp_op;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regbank_wb_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .a_valid     (a_valid),
    .a_reg       (a_reg),
    .a_data      (a_data),
    .a_ready     (a_ready),
    .b_valid     (b_valid),
    .b_reg       (b_reg),
    .b_data      (b_data),
    .b_ready     (b_ready),
    .issue_valid (issue_valid),
    .issue_reg   (issue_reg),
    .busy        (busy),
    .sp_op       (sp_op),
    .sp_in       (sp_in),
    .reg_write   (reg_write),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .sp_write    (sp_write),
    .sp_wdata    (sp_wdata),
    .sp_fault    (sp_fault)
  );

  typedef struct {
    logic rst; logic av; logic [4:0] ar; logic [31:0] ad;
    logic bv; logic [4:0] br; logic [31:0] bd;
    logic iv; logic [4:0] ir; logic [1:0] op; logic [31:0] spi;
    logic e_ar; logic e_br; logic e_rw; logic [4:0] e_wr; logic [31:0] e_wd;
    logic [15:0] e_busy; logic e_spw; logic [31:0] e_spd; logic e_flt; logic chk_spd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t vr(
    input logic rst_i, input logic av, input logic [4:0] ar, input logic [31:0] ad,
    input logic bv, input logic [4:0] br, input logic [31:0] bd,
    input logic iv, input logic [4:0] ir, input logic [1:0] op, input logic [31:0] spi,
    input logic e_ar, input logic e_br, input logic e_rw, input logic [4:0] e_wr,
    input logic [31:0] e_wd, input logic [15:0] e_busy, input logic e_spw,
    input logic [31:0] e_spd, input logic e_flt, input logic chk_spd);
    vec_t v;
    v.rst = rst_i; v.av = av; v.ar = ar; v.ad = ad; v.bv = bv; v.br = br; v.bd = bd;
    v.iv = iv; v.ir = ir; v.op = op; v.spi = spi;
    v.e_ar = e_ar; v.e_br = e_br; v.e_rw = e_rw; v.e_wr = e_wr; v.e_wd = e_wd;
    v.e_busy = e_busy; v.e_spw = e_spw; v.e_spd = e_spd; v.e_flt = e_flt; v.chk_spd = chk_spd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; a_valid = v.av; a_reg = v.ar; a_data = v.ad;
    b_valid = v.bv; b_reg = v.br; b_data = v.bd;
    issue_valid = v.iv; issue_reg = v.ir; sp_op = v.op; sp_in = v.spi;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; a_valid = 1'b0; a_reg = '0; a_data = '0;
    b_valid = 1'b0; b_reg = '0; b_data = '0;
    issue_valid = 1'b0; issue_reg = '0; sp_op = 2'b00; sp_in = '0;
  endtask

  // Behavioural model state for the randomized phase
  int          m_prio;      // 0: A preferred on contention, 1: B
  logic [15:0] m_pend;
  logic        m_flt;
  logic        hold_a, hold_b;

  function automatic logic [4:0] rnd_reg();
    return ($urandom_range(0, 7) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
  endfunction

  function automatic logic [31:0] rnd_sp();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFE;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] exp_wd;
    logic [4:0]  exp_wr;
    logic        exp_rw, exp_spw, ea, eb;
    logic [31:0] exp_spd;
    longint      s;
    int          na, nb, r;

    tbl.push_back(vr(1, 0,0,0, 0,0,0, 0,0, 2'd0,0, 0,0,0,0,0, 16'h0000, 0,0,0,1));
    tbl.push_back(vr(0, 1,3,32'hDEADBEEF, 0,0,0, 0,0, 2'd0,0, 1,0,1,3,32'hDEADBEEF, 16'h0000, 0,0,0,0));
    tbl.push_back(vr(0, 0,0,0, 0,0,0, 0,0, 2'd0,0, 0,0,0,0,0, 16'h0000, 0,0,0,0));
    tbl.push_back(vr(0, 1,4,32'h11, 1,5,32'h22, 0,0, 2'd0,0, 1,0,1,4,32'h11, 16'h0000, 0,0,0,0));
    tbl.push_back(vr(0, 1,4,32'h11, 1,5,32'h22, 0,0, 2'd0,0, 0,1,1,5,32'h22, 16'h0000, 0,0,0,0));
    tbl.push_back(vr(0, 0,0,0, 0,0,0, 0,0, 2'd0,0, 0,0,0,0,0, 16'h0000, 0,0,0,0));
    tbl.push_back(vr(0, 0,0,0, 0,0,0, 1,7, 2'd0,0, 0,0,0,0,0, 16'h0080, 0,0,0,0));
    tbl.push_back(vr(0, 1,7,32'h77, 0,0,0, 1,7, 2'd0,0, 1,0,1,7,32'h77, 16'h0080, 0,0,0,0));
    tbl.push_back(vr(0, 1,7,32'h78, 0,0,0, 0,0, 2'd0,0, 1,0,1,7,32'h78, 16'h0000, 0,0,0,0));
    tbl.push_back(vr(0, 1,0,32'h5, 0,0,0, 0,0, 2'd0,0, 1,0,0,0,0, 16'h0000, 0,0,0,0));
    tbl.push_back(vr(0, 1,0,32'h5, 1,6,32'h66, 0,0, 2'd0,0, 1,0,0,0,0, 16'h0000, 0,0,0,0));
    tbl.push_back(vr(0, 1,8,32'h88, 1,6,32'h66, 0,0, 2'd0,0, 0,1,1,6,32'h66, 16'h0000, 0,0,0,0));
    tbl.push_back(vr(0, 1,17,32'h1, 0,0,0, 1,20, 2'd0,0, 1,0,0,0,0, 16'h0000, 0,0,0,0));
    tbl.push_back(vr(0, 0,0,0, 1,16,32'hAB, 0,0, 2'd0,0, 0,1,0,0,0, 16'h0000, 0,0,0,0));
    tbl.push_back(vr(0, 0,0,0, 0,0,0, 0,0, 2'd1,32'd16, 0,0,0,0,0, 16'h0000, 1,32'd15,0,0));
    tbl.push_back(vr(0, 0,0,0, 0,0,0, 0,0, 2'd2,32'hFFFFFFFE, 0,0,0,0,0, 16'h0000, 1,32'hFFFFFFFF,0,0));
    tbl.push_back(vr(0, 0,0,0, 0,0,0, 0,0, 2'd2,32'hFFFFFFFF, 0,0,0,0,0, 16'h0000, 0,32'hFFFFFFFF,1,1));
    tbl.push_back(vr(0, 0,0,0, 0,0,0, 0,0, 2'd1,32'd0, 0,0,0,0,0, 16'h0000, 0,32'hFFFFFFFF,1,1));
    tbl.push_back(vr(0, 0,0,0, 0,0,0, 0,0, 2'd3,32'd5, 0,0,0,0,0, 16'h0000, 0,32'hFFFFFFFF,1,1));
    tbl.push_back(vr(0, 1,2,32'h22, 0,0,0, 0,0, 2'd1,32'd1, 1,0,1,2,32'h22, 16'h0000, 1,32'd0,1,0));
    tbl.push_back(vr(1, 1,9,32'h9, 0,0,0, 1,9, 2'd1,32'd10, 0,0,0,0,0, 16'h0000, 0,32'd0,0,1));
    tbl.push_back(vr(0, 0,0,0, 0,0,0, 0,0, 2'd0,0, 0,0,0,0,0, 16'h0000, 0,0,0,0));

    // Directed vector table, one row per clock
    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k]);
      @(negedge clk);
      chk($sformatf("row%0d a_ready", k), 64'(a_ready), 64'(tbl[k].e_ar));
      chk($sformatf("row%0d b_ready", k), 64'(b_ready), 64'(tbl[k].e_br));
      @(posedge clk); #1;
      chk($sformatf("row%0d reg_write", k), 64'(reg_write), 64'(tbl[k].e_rw));
      chk($sformatf("row%0d busy", k), 64'(busy), 64'(tbl[k].e_busy));
      chk($sformatf("row%0d sp_write", k), 64'(sp_write), 64'(tbl[k].e_spw));
      chk($sformatf("row%0d sp_fault", k), 64'(sp_fault), 64'(tbl[k].e_flt));
      if (tbl[k].e_rw || tbl[k].rst) begin
        chk($sformatf("row%0d write_reg", k), 64'(write_reg), 64'(tbl[k].e_wr));
        chk($sformatf("row%0d write_data", k), 64'(write_data), 64'(tbl[k].e_wd));
      end
      if (tbl[k].e_spw || tbl[k].rst || tbl[k].chk_spd)
        chk($sformatf("row%0d sp_wdata", k), 64'(sp_wdata), 64'(tbl[k].e_spd));
    end

    // Sustained contention: the loser holds its payload until granted, grants alternate
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    na = 0; nb = 0;
    for (int c = 0; c < 6; c++) begin
      a_valid = 1'b1; a_reg = 5'd10; a_data = 32'hA0 + 32'(na);
      b_valid = 1'b1; b_reg = 5'd11; b_data = 32'hB0 + 32'(nb);
      exp_wr = (c % 2 == 0) ? 5'd10 : 5'd11;
      exp_wd = (c % 2 == 0) ? a_data : b_data;
      @(negedge clk);
      chk($sformatf("rr%0d a_ready", c), 64'(a_ready), 64'(c % 2 == 0));
      chk($sformatf("rr%0d b_ready", c), 64'(b_ready), 64'(c % 2 == 1));
      @(posedge clk); #1;
      chk($sformatf("rr%0d reg_write", c), 64'(reg_write), 64'd1);
      chk($sformatf("rr%0d write_reg", c), 64'(write_reg), 64'(exp_wr));
      chk($sformatf("rr%0d write_data", c), 64'(write_data), 64'(exp_wd));
      if (c % 2 == 0) na++; else nb++;
    end

    // Randomized traffic against the behavioural model
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    m_prio = 0; m_pend = '0; m_flt = 1'b0; hold_a = 1'b0; hold_b = 1'b0;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 39) == 0);
      if (!hold_a) begin
        a_valid = ($urandom_range(0, 2) != 0); a_reg = rnd_reg(); a_data = $urandom;
      end
      if (!hold_b) begin
        b_valid = ($urandom_range(0, 2) != 0); b_reg = rnd_reg(); b_data = $urandom;
      end
      issue_valid = ($urandom_range(0, 1) != 0);
      issue_reg   = rnd_reg();
      sp_op       = 2'($urandom_range(0, 3));
      sp_in       = rnd_sp();

      ea = 1'b0; eb = 1'b0;
      if (!rst) begin
        if (a_valid && b_valid) begin
          if (m_prio == 0) ea = 1'b1; else eb = 1'b1;
          m_prio = 1 - m_prio;
        end else begin
          ea = a_valid; eb = b_valid;
        end
      end
      exp_rw = 1'b0; exp_wr = '0; exp_wd = '0; exp_spw = 1'b0; exp_spd = '0;
      if (rst) begin
        m_prio = 0; m_pend = '0; m_flt = 1'b0;
      end else begin
        r = ea ? int'(a_reg) : int'(b_reg);
        if ((ea || eb) && r >= 1 && r <= 15) begin
          exp_rw = 1'b1; exp_wr = 5'(r); exp_wd = ea ? a_data : b_data;
          m_pend[r] = 1'b0;
        end
        if (issue_valid && issue_reg >= 1 && issue_reg <= 15) m_pend[issue_reg] = 1'b1;
        s = sp_in;
        if (sp_op == 2'd1) begin
          if (s - 1 < 0) m_flt = 1'b1;
          else begin exp_spw = 1'b1; exp_spd = 32'(s - 1); end
        end else if (sp_op == 2'd2) begin
          if (s + 1 > 64'hFFFF_FFFF) m_flt = 1'b1;
          else begin exp_spw = 1'b1; exp_spd = 32'(s + 1); end
        end
      end

      @(negedge clk);
      chk($sformatf("rnd%0d a_ready", c), 64'(a_ready), 64'(ea));
      chk($sformatf("rnd%0d b_ready", c), 64'(b_ready), 64'(eb));
      @(posedge clk); #1;
      chk($sformatf("rnd%0d reg_write", c), 64'(reg_write), 64'(exp_rw));
      if (exp_rw) begin
        chk($sformatf("rnd%0d write_reg", c), 64'(write_reg), 64'(exp_wr));
        chk($sformatf("rnd%0d write_data", c), 64'(write_data), 64'(exp_wd));
      end
      chk($sformatf("rnd%0d busy", c), 64'(busy), 64'(m_pend));
      chk($sformatf("rnd%0d sp_write", c), 64'(sp_write), 64'(exp_spw));
      if (exp_spw) chk($sformatf("rnd%0d sp_wdata", c), 64'(sp_wdata), 64'(exp_spd));
      chk($sformatf("rnd%0d sp_fault", c), 64'(sp_fault), 64'(m_flt));

      hold_a = !rst && a_valid && !ea;
      hold_b = !rst && b_valid && !eb;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
